i2s_sample_tx: RTL



---
 rtl/i2s_sample_tx.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/i2s_sample_tx.sv
// i2s_sample_tx
//   Buffers stereo PCM pairs in a small FIFO and serializes one pair per
//   frame as Philips I2S. The frame is 64 bit-clocks, 32 per slot. The
//   data is delayed by one bit-clock after the word-select edge and is sent
//   MSB first. Everything runs on the single audio clock.
//
// Parameters
//   SAMPLE_W   bits per channel sample (1..31)
//   FIFO_DEPTH sample-pair entries (power of two, >= 2)
//   SCLK_DIV   clk cycles per i2s_sclk half-period (>= 1)
//
// Ports
//   clk, rst      audio clock; synchronous active-high reset
//   sample_valid  producer has a pair on sample_l/sample_r
//   sample_ready  FIFO can accept a pair (= !full)
//   sample_l/r    left/right two's-complement samples
//   fifo_level    registered count of stored pairs
//   underrun      one-cycle pulse when a frame starts with the FIFO empty
//   i2s_sclk      bit clock
//   i2s_lrclk     word select (0 = left slot, 1 = right slot)
//   i2s_sda       serial data
//
// Handshake: a pair is transferred on every rising clk edge where
//   sample_valid && sample_ready. sample_ready depends only on registered
//   state, so a pop in the same cycle never admits a push into a full FIFO.
//
// Optional build macro I2S_TX_HOLD_LAST_EN: when defined, an underrun repeats
//   the last pair instead of sending silence. The underrun pulse is unchanged.

module i2s_sample_tx #(
  parameter int SAMPLE_W   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SCLK_DIV   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [SAMPLE_W-1:0]           sample_l,
  input  logic [SAMPLE_W-1:0]           sample_r,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          i2s_sclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sda
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

  // FIFO storage and bookkeeping
  logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Bit-clock generation and serializer state
  logic [DW-1:0]         div_cnt;
  logic                  div_wrap;
  logic                  fall_edge;
  logic                  frame_start;
  logic [5:0]            bit_cnt;
  logic [5:0]            bit_nxt;
  logic [SAMPLE_W-1:0]   shadow_l;
  logic [SAMPLE_W-1:0]   shadow_r;
  logic [SAMPLE_W-1:0]   shadow_sel;
  logic [31:0]           slot_img;
  logic                  sda_nxt;

  assign full         = (count == LW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign sample_ready = !full;
  assign fifo_level   = count;

  assign div_wrap    = (div_cnt == DW'(SCLK_DIV - 1));
  // A falling edge is the registered toggle taking sclk from 1 to 0.
  assign fall_edge   = div_wrap && i2s_sclk;
  assign frame_start = fall_edge && (bit_cnt == 6'd63);
  assign bit_nxt     = bit_cnt + 6'd1;

  assign push = sample_valid && !full;
  // The pop sees the pre-push state, so an empty FIFO underruns even when
  // a pair arrives in the same cycle.
  assign pop  = frame_start && !empty;

  // The slot image places slot position k at bit (31 - k). The sample
  // occupies positions 1..SAMPLE_W, which gives the one-bit I2S delay.
  // All other positions shift in as zero.
  always_comb begin
    shadow_sel = bit_nxt[5] ? shadow_r : shadow_l;
    slot_img   = {{(32 - SAMPLE_W){1'b0}}, shadow_sel} << (31 - SAMPLE_W);
    sda_nxt    = slot_img[~bit_nxt[4:0]];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {sample_l, sample_r};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      i2s_sclk  <= 1'b0;
      i2s_lrclk <= 1'b1;
      i2s_sda   <= 1'b0;
      bit_cnt   <= 6'd63;
      underrun  <= 1'b0;
      shadow_l  <= '0;
      shadow_r  <= '0;
    end else begin
      underrun <= 1'b0;

      if (div_wrap) begin
        div_cnt  <= '0;
        i2s_sclk <= ~i2s_sclk;
      end else begin
        div_cnt  <= div_cnt + DW'(1);
      end

      if (fall_edge) begin
        bit_cnt   <= bit_nxt;
        i2s_lrclk <= bit_nxt[5];
        i2s_sda   <= sda_nxt;
      end

      if (frame_start) begin
        if (!empty) begin
          {shadow_l, shadow_r} <= mem[rd_ptr];
        end else begin
          underrun <= 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
          shadow_l <= shadow_l;
          shadow_r <= shadow_r;
`else
          shadow_l <= '0;
          shadow_r <= '0;
`endif
        end
      end
    end
  end

endmodule
